branch_perf_monitor: RTL and testbench
======================================

BRANCH_PERF_MONITOR -- requirements
Module: branch_perf_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 32, counter and read-data width.
REQ-002 SHALL have parameter FLUSH_PENALTY, default 4, cycles lost per misprediction flush.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on posedge.
REQ-004 SHALL have port rst_BF, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, clears counters and begins a measurement window.
REQ-006 SHALL have port stop, input, 1, ends the measurement window.
REQ-007 SHALL have port hit_2, input, 1, branch resolved this cycle.
REQ-008 SHALL have port stall_2, input, 1, pipeline stalled this cycle.
REQ-009 SHALL have port rst_out, input, 1, misprediction flush this cycle.
REQ-010 SHALL have port rd_req, input, 1, read request.
REQ-011 SHALL have port rd_sel, input, 3, counter select.
REQ-012 SHALL have port rd_ack, output, 1, read-data valid pulse.
REQ-013 SHALL have port rd_data, output, CNT_W, selected counter value.
REQ-014 SHALL have port running, output, 1, high in state RUN.
REQ-015 SHALL have port ovf, output, 4, sticky per-counter wrap flags {mispred, branch, stall, cycle}.

Function
REQ-016 SHALL implement states IDLE, RUN, FROZEN; running = (state == RUN).
REQ-017 start in any state SHALL zero all counters and ovf and enter RUN next cycle; counting begins the cycle after start.
REQ-018 stop in RUN SHALL enter FROZEN next cycle; events of the stop cycle SHALL be counted; stop in IDLE/FROZEN ignored.
REQ-019 start and stop in the same cycle: start wins.
REQ-020 In RUN, each cycle SHALL increment cycle_cnt by 1, stall_cnt if stall_2, branch_cnt if hit_2, mispred_cnt if rst_out; simultaneous events each counted independently.
REQ-021 In IDLE and FROZEN counters SHALL hold; inputs ignored.
REQ-022 Counters SHALL wrap modulo 2^CNT_W.
REQ-023 A read SHALL be accepted when rd_req=1 and rd_ack=0; rd_ack SHALL pulse high exactly one cycle later with rd_data registered from values at acceptance cycle; max one read per two cycles.
REQ-024 rd_sel: 0 cycle_cnt, 1 stall_cnt, 2 branch_cnt, 3 mispred_cnt, 4 inst_cnt, 5-7 return 0.
REQ-025 inst_cnt SHALL equal cycle_cnt - stall_cnt - FLUSH_PENALTY*mispred_cnt computed in CNT_W+4 bits, clamped to 0 if negative, truncated to CNT_W.
REQ-026 rd_data SHALL hold its last value while rd_ack=0.
REQ-027 Reads SHALL be legal in every state and SHALL NOT disturb counting.

Reset
REQ-028 rst_BF SHALL force IDLE, all counters 0, rd_ack 0, rd_data 0, ovf 0, running 0 on the next edge; overrides start, stop and an in-flight read.

Configuration
REQ-029 With PERF_OVF_EN defined, a counter wrapping from all-ones to 0 SHALL set its ovf bit, held until start or rst_BF.
REQ-030 Without PERF_OVF_EN, ovf SHALL be constant 0 and no flag registers SHALL exist.

Structure
REQ-031 Shared package perf_pkg SHALL hold the state enum, rd_sel encodings and FLUSH_PENALTY default.
REQ-032 One sub-module perf_counter (CNT_W-wide clear/enable counter with wrap output) SHALL be instantiated four times.

Verification
REQ-033 Reset, start, 10 RUN cycles with hit_2 on cycles 2,5,7, stop; read sel 0 -> 10, sel 2 -> 3.
REQ-034 20 RUN cycles, stall_2 3 cycles, rst_out 2 cycles (one coinciding with a stall) -> sel 1 = 3, sel 3 = 2, sel 4 = 20-3-8 = 9.
REQ-035 5 RUN cycles, rst_out 3 cycles -> sel 4 = 0 (clamped).
REQ-036 CNT_W=4, PERF_OVF_EN, 17 RUN cycles -> sel 0 = 1, ovf[0]=1; without macro ovf=0.
REQ-037 rd_req held high 4 cycles -> rd_ack high on cycles 2 and 4 only; rst_BF on cycle 3 -> rd_ack 0 and counters 0 next cycle.
REQ-038 start and stop asserted together in FROZEN -> counters 0, state RUN next cycle.

Source files
------------

// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared types and encodings for the branch performance monitor
//
// Contents: measurement-window state enum, rd_sel encodings, ovf/event bit
// positions and the default flush penalty.
package perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } perf_state_t;

  // Read-select encodings; anything above SEL_INST reads as zero.
  localparam logic [2:0] SEL_CYCLE   = 3'd0;
  localparam logic [2:0] SEL_STALL   = 3'd1;
  localparam logic [2:0] SEL_BRANCH  = 3'd2;
  localparam logic [2:0] SEL_MISPRED = 3'd3;
  localparam logic [2:0] SEL_INST    = 3'd4;

  // Bit positions inside the event/wrap/ovf vectors {mispred, branch, stall, cycle}.
  localparam int EV_CYCLE   = 0;
  localparam int EV_STALL   = 1;
  localparam int EV_BRANCH  = 2;
  localparam int EV_MISPRED = 3;

  localparam int FLUSH_PENALTY_DEFAULT = 4;

endpackage

// File: rtl/perf_counter.sv
// rtl/perf_counter.sv - clear/enable event counter with wrap indication
//
// Ports:
//   clk   - clock, all updates on posedge
//   clr   - synchronous clear, has priority over en
//   en    - count one event this cycle
//   count - current counter value (wraps modulo 2^CNT_W)
//   wrap  - high in the cycle whose increment takes count from all-ones to zero
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign wrap = en & ~clr & (&count);

endmodule

// File: rtl/branch_perf_monitor.sv
// rtl/branch_perf_monitor.sv - branch/stall performance counters with a start/stop window
//
// Ports:
//   clk, rst_BF          - clock and synchronous active-high reset
//   start, stop          - open (and clear) / close the measurement window
//   hit_2, stall_2       - branch resolved / pipeline stalled this cycle
//   rst_out              - misprediction flush this cycle
//   rd_req, rd_sel       - read request and counter select
//   rd_ack, rd_data      - one-cycle read-valid pulse and registered read data
//   running              - window is open (state RUN)
//   ovf                  - sticky wrap flags {mispred, branch, stall, cycle}
// Build option: PERF_OVF_EN enables the sticky wrap flags; otherwise ovf is 0.
module branch_perf_monitor
  import perf_pkg::*;
#(
  parameter int CNT_W         = 32,
  parameter int FLUSH_PENALTY = FLUSH_PENALTY_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_BF,
  input  logic             start,
  input  logic             stop,
  input  logic             hit_2,
  input  logic             stall_2,
  input  logic             rst_out,
  input  logic             rd_req,
  input  logic [2:0]       rd_sel,
  output logic             rd_ack,
  output logic [CNT_W-1:0] rd_data,
  output logic             running,
  output logic [3:0]       ovf
);

  // Wide enough that cycle - stall - penalty*mispred cannot overflow, so the
  // top bit is a reliable sign for the clamp.
  localparam int EW = CNT_W + 4;

  perf_state_t      state;
  logic             cnt_clr;
  logic             cnt_run;
  logic [3:0]       ev;
  logic [3:0]       wrap;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;
  logic [EW-1:0]    inst_wide;
  logic [CNT_W-1:0] inst_cnt;
  logic [CNT_W-1:0] sel_val;
  logic             rd_accept;

  // Window control. start wins over stop; stop only matters while running.
  always_ff @(posedge clk) begin
    if (rst_BF) begin
      state   <= ST_IDLE;
      running <= 1'b0;
    end else if (start) begin
      state   <= ST_RUN;
      running <= 1'b1;
    end else if (state == ST_RUN && stop) begin
      state   <= ST_FROZEN;
      running <= 1'b0;
    end
  end

  // start clears the counters in its own cycle, so counting effectively
  // begins on the following cycle; a stop cycle is still counted.
  assign cnt_clr = rst_BF | start;
  assign cnt_run = (state == ST_RUN);

  always_comb begin
    ev             = '0;
    ev[EV_CYCLE]   = cnt_run;
    ev[EV_STALL]   = cnt_run & stall_2;
    ev[EV_BRANCH]  = cnt_run & hit_2;
    ev[EV_MISPRED] = cnt_run & rst_out;
  end

  perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .clr   (cnt_clr),
    .en    (ev[EV_CYCLE]),
    .count (cycle_cnt),
    .wrap  (wrap[EV_CYCLE])
  );

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (cnt_clr),
    .en    (ev[EV_STALL]),
    .count (stall_cnt),
    .wrap  (wrap[EV_STALL])
  );

  perf_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .clr   (cnt_clr),
    .en    (ev[EV_BRANCH]),
    .count (branch_cnt),
    .wrap  (wrap[EV_BRANCH])
  );

  perf_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .clr   (cnt_clr),
    .en    (ev[EV_MISPRED]),
    .count (mispred_cnt),
    .wrap  (wrap[EV_MISPRED])
  );

  // Useful instructions: cycles not lost to stalls or flush penalties.
  assign inst_wide = EW'(cycle_cnt) - EW'(stall_cnt)
                   - EW'(FLUSH_PENALTY) * EW'(mispred_cnt);
  assign inst_cnt  = inst_wide[EW-1] ? '0 : inst_wide[CNT_W-1:0];

  always_comb begin
    sel_val = '0;
    case (rd_sel)
      SEL_CYCLE:   sel_val = cycle_cnt;
      SEL_STALL:   sel_val = stall_cnt;
      SEL_BRANCH:  sel_val = branch_cnt;
      SEL_MISPRED: sel_val = mispred_cnt;
      SEL_INST:    sel_val = inst_cnt;
      default:     sel_val = '0;
    endcase
  end

  // A request is taken only while no ack is showing, which limits reads to
  // one every two cycles. Data is captured from pre-update counter values.
  assign rd_accept = rd_req & ~rd_ack;

  always_ff @(posedge clk) begin
    if (rst_BF) begin
      rd_ack  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_ack <= rd_accept;
      if (rd_accept) begin
        rd_data <= sel_val;
      end
    end
  end

`ifdef PERF_OVF_EN
  logic [3:0] ovf_q;

  always_ff @(posedge clk) begin
    if (cnt_clr) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_q | wrap;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_wrap;

  assign ovf         = '0;
  assign unused_wrap = ^wrap;
`endif

endmodule

// File: tb/tb_branch_perf_monitor.sv
// tb/tb_branch_perf_monitor.sv - self-checking bench for branch_perf_monitor
module tb_branch_perf_monitor;

  localparam int FP = 4;

  logic        clk = 1'b0;
  logic        rst_BF, start, stop, hit_2, stall_2, rst_out, rd_req;
  logic [2:0]  rd_sel;
  logic        rd_ack, running;
  logic [31:0] rd_data;
  logic [3:0]  ovf;
  logic        rd_ack4, running4;
  logic [3:0]  rd_data4;
  logic [3:0]  ovf4;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Behavioural model: unbounded event totals since the last clear; each
  // DUT width sees them modulo 2^W.
  longint n_cyc = 0, n_stl = 0, n_br = 0, n_mp = 0;
  int     m_mode = 0;   // 0 idle, 1 run, 2 frozen
  bit     m_ack = 1'b0;
  longint m_data32 = 0, m_data4 = 0;

  always #5 clk = ~clk;

  branch_perf_monitor dut (
    .clk(clk), .rst_BF(rst_BF), .start(start), .stop(stop), .hit_2(hit_2),
    .stall_2(stall_2), .rst_out(rst_out), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_ack(rd_ack), .rd_data(rd_data), .running(running), .ovf(ovf)
  );

  branch_perf_monitor #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_BF(rst_BF), .start(start), .stop(stop), .hit_2(hit_2),
    .stall_2(stall_2), .rst_out(rst_out), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_ack(rd_ack4), .rd_data(rd_data4), .running(running4), .ovf(ovf4)
  );

  function automatic longint wrapv(input int w, input longint n);
    longint lim;
    lim = longint'(1) << w;
    return n % lim;
  endfunction

  function automatic longint sel_val(input int w, input int s);
    longint c, st, br, mp, d;
    c  = wrapv(w, n_cyc);
    st = wrapv(w, n_stl);
    br = wrapv(w, n_br);
    mp = wrapv(w, n_mp);
    d  = c - st - FP * mp;
    case (s)
      0: return c;
      1: return st;
      2: return br;
      3: return mp;
      4: return (d < 0) ? 0 : d;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] ovf_exp(input int w);
`ifdef PERF_OVF_EN
    longint lim;
    lim = longint'(1) << w;
    return {n_mp >= lim, n_br >= lim, n_stl >= lim, n_cyc >= lim};
`else
    return 4'd0;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst_BF) begin
      m_mode = 0; m_ack = 1'b0; m_data32 = 0; m_data4 = 0;
      n_cyc = 0; n_stl = 0; n_br = 0; n_mp = 0;
    end else begin
      if (rd_req && !m_ack) begin
        m_ack    = 1'b1;
        m_data32 = sel_val(32, int'(rd_sel));
        m_data4  = sel_val(4, int'(rd_sel));
      end else begin
        m_ack = 1'b0;
      end
      if (start) begin
        n_cyc = 0; n_stl = 0; n_br = 0; n_mp = 0;
        m_mode = 1;
      end else if (m_mode == 1) begin
        n_cyc++;
        if (stall_2) n_stl++;
        if (hit_2)   n_br++;
        if (rst_out) n_mp++;
        if (stop) m_mode = 2;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input longint exp);
    tests++;
    if (act !== 64'(exp)) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("running",  running,  m_mode == 1);
      chk("running4", running4, m_mode == 1);
      chk("rd_ack",   rd_ack,   m_ack);
      chk("rd_ack4",  rd_ack4,  m_ack);
      chk("rd_data",  rd_data,  m_data32);
      chk("rd_data4", rd_data4, m_data4);
      chk("ovf",      ovf,      ovf_exp(32));
      chk("ovf4",     ovf4,     ovf_exp(4));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [2:0] s, output logic [31:0] d, output logic [3:0] d4);
    rd_req = 1'b1;
    rd_sel = s;
    tick();
    chk("read_ack_pulse", rd_ack, 1);
    d  = rd_data;
    d4 = rd_data4;
    rd_req = 1'b0;
    tick();
  endtask

  task automatic open_window();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [31:0] d;
  logic [3:0]  d4;
  longint      ovf_on;

  initial begin
`ifdef PERF_OVF_EN
    ovf_on = 1;
`else
    ovf_on = 0;
`endif
    rst_BF = 1'b1; start = 1'b0; stop = 1'b0; hit_2 = 1'b0; stall_2 = 1'b0;
    rst_out = 1'b0; rd_req = 1'b0; rd_sel = 3'd0;
    tick();
    tick();
    rst_BF = 1'b0;
    chk_en = 1'b1;
    chk("reset_running", running, 0);
    chk("reset_rd_ack",  rd_ack,  0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_ovf",     ovf,     0);

    // 10 cycles, branches on cycles 2, 5, 7, stop on the last.
    open_window();
    for (int i = 1; i <= 10; i++) begin
      hit_2 = (i == 2 || i == 5 || i == 7);
      stop  = (i == 10);
      tick();
    end
    hit_2 = 1'b0; stop = 1'b0;
    chk("frozen_running", running, 0);
    do_read(3'd0, d, d4);
    chk("w10_cycle", d, 10);
    chk("w10_cycle4", d4, 10);
    do_read(3'd2, d, d4);
    chk("w10_branch", d, 3);

    // 20 cycles, stalls 3,4,9, flushes 9,15.
    open_window();
    for (int i = 1; i <= 20; i++) begin
      stall_2 = (i == 3 || i == 4 || i == 9);
      rst_out = (i == 9 || i == 15);
      stop    = (i == 20);
      tick();
    end
    stall_2 = 1'b0; rst_out = 1'b0; stop = 1'b0;
    do_read(3'd1, d, d4);
    chk("w20_stall", d, 3);
    do_read(3'd3, d, d4);
    chk("w20_mispred", d, 2);
    do_read(3'd4, d, d4);
    chk("w20_inst", d, 9);
    chk("w20_inst4_clamp", d4, 0);
    do_read(3'd0, d, d4);
    chk("w20_cycle", d, 20);
    chk("w20_cycle4_wrapped", d4, 4);
    chk("w20_ovf4_cycle", ovf4[0], ovf_on);
    do_read(3'd6, d, d4);
    chk("sel6_zero", d, 0);

    // 5 cycles with 3 flushes: negative instruction count clamps to 0.
    open_window();
    for (int i = 1; i <= 5; i++) begin
      rst_out = (i <= 3);
      stop    = (i == 5);
      tick();
    end
    rst_out = 1'b0; stop = 1'b0;
    do_read(3'd4, d, d4);
    chk("w5_inst_clamp", d, 0);
    do_read(3'd3, d, d4);
    chk("w5_mispred", d, 3);

    // 17 cycles: the 4-bit cycle counter wraps once.
    open_window();
    for (int i = 1; i <= 17; i++) begin
      stop = (i == 17);
      tick();
    end
    stop = 1'b0;
    do_read(3'd0, d, d4);
    chk("w17_cycle4", d4, 1);
    chk("w17_cycle", d, 17);
    chk("w17_ovf4", ovf4, ovf_on);
    chk("w17_ovf", ovf, 0);

    // Held request: ack on the 2nd and 4th cycles only.
    open_window();
    rd_req = 1'b1; rd_sel = 3'd0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("held_req_ack", rd_ack, (i == 1 || i == 3) ? 1 : 0);
    end
    rd_req = 1'b0;
    tick();

    // Held request with reset in the third cycle.
    rd_req = 1'b1;
    tick();
    chk("rst_req_ack_c2", rd_ack, 1);
    tick();
    chk("rst_req_ack_c3", rd_ack, 0);
    rst_BF = 1'b1;
    tick();
    rst_BF = 1'b0;
    chk("rst_req_ack_c4", rd_ack, 0);
    chk("rst_req_data_c4", rd_data, 0);
    chk("rst_req_running", running, 0);
    tick();
    chk("rst_req_ack_c5", rd_ack, 1);
    chk("rst_req_cnt_zero", rd_data, 0);
    rd_req = 1'b0;
    tick();

    // start+stop together while frozen.
    open_window();
    tick(); tick(); tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    chk("pre_startstop_frozen", running, 0);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("startstop_running", running, 1);
    do_read(3'd0, d, d4);
    chk("startstop_cleared", d, 0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst_BF  = ($urandom_range(0, 299) == 0);
      start   = ($urandom_range(0, 59) == 0);
      stop    = ($urandom_range(0, 39) == 0);
      hit_2   = ($urandom_range(0, 2) == 0);
      stall_2 = ($urandom_range(0, 2) == 0);
      rst_out = ($urandom_range(0, 3) == 0);
      rd_req  = ($urandom_range(0, 1) == 0);
      rd_sel  = 3'($urandom_range(0, 7));
      tick();
    end
    rst_BF = 1'b0; start = 1'b0; stop = 1'b0; hit_2 = 1'b0;
    stall_2 = 1'b0; rst_out = 1'b0; rd_req = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
